// File: rtl/sprite_row_fetcher.sv
// Sprite row fetcher: during horizontal blanking, snapshots the sprite
// attributes. For every sprite that covers the coming line, it streams that
// sprite's 32-pixel row out of the shared image ROM and into the row buffers.
//
// Handshake: there is no back-pressure anywhere. An address driven on
// rom_addr is answered on rom_q exactly ROM_LAT cycles later. Each buf_we
// cycle is a single-cycle write with buf_sel/buf_col/buf_data valid in that
// same cycle.
module sprite_row_fetcher #(
  parameter int NUM_SPR = 4,
  parameter int ROM_LAT = 1,
  parameter int HACTIVE = 1280,
  parameter int VACTIVE = 480,
  parameter int VTOTAL  = 525,
  localparam int SW     = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          hcount,
  input  logic [9:0]           vcount,
  input  logic [NUM_SPR-1:0]   spr_en,
  input  logic [NUM_SPR*10-1:0] spr_y,
  input  logic [NUM_SPR*5-1:0] spr_img,
  output logic [14:0]          rom_addr,
  input  logic [3:0]           rom_q,
  output logic                 buf_we,
  output logic [SW-1:0]        buf_sel,
  output logic [4:0]           buf_col,
  output logic [3:0]           buf_data,
  output logic [NUM_SPR-1:0]   row_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] FETCH = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int DW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(ROM_LAT - 1);
  localparam logic [SW-1:0] SPR_LAST   = SW'(NUM_SPR - 1);
  localparam logic [10:0]   H_TRIG     = 11'(HACTIVE);
  localparam logic [9:0]    V_LAST     = 10'(VTOTAL - 1);
  localparam logic [9:0]    V_ACT      = 10'(VACTIVE);

  logic [2:0]         state_q, state_d;
  logic [SW-1:0]      spr_q, spr_d;
  logic [4:0]         col_q, col_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [4:0]         row_q, row_d;
  logic [14:0]        rom_addr_q, rom_addr_d;
  logic [NUM_SPR-1:0] row_valid_q, row_valid_d;
  logic               overrun_q, overrun_d;
  logic [9:0]         next_row_q;

  // Attribute snapshot taken at the trigger
  logic [NUM_SPR-1:0] en_snap_q;
  logic [9:0]         y_snap_q   [NUM_SPR];
  logic [4:0]         img_snap_q [NUM_SPR];

  // Write pipeline, one stage per cycle of ROM latency
  logic               pv_q [ROM_LAT];
  logic [SW-1:0]      ps_q [ROM_LAT];
  logic [4:0]         pc_q [ROM_LAT];

  logic       trig;
  logic       trig_idle;
  logic       en_cur;
  logic [9:0] y_cur;
  logic [4:0] img_cur;
  logic       hit;
  logic [4:0] row_calc;
  logic [10:0] nr11, y11;

  assign trig      = (hcount == H_TRIG);
  assign trig_idle = trig && (state_q == IDLE);
  assign en_cur    = en_snap_q[spr_q];
  assign y_cur     = y_snap_q[spr_q];
  assign img_cur   = img_snap_q[spr_q];
  assign nr11      = {1'b0, next_row_q};
  assign y11       = {1'b0, y_cur};
  // 11-bit compare so that y+32 near the top of the 10-bit range cannot wrap
  assign hit       = en_cur && (next_row_q < V_ACT) && (nr11 >= y11) &&
                     (nr11 < (y11 + 11'd32));
  // Only the low five bits of the row offset matter once hit is true
  assign row_calc  = next_row_q[4:0] - y_cur[4:0];

  // Sequencer next-state logic
  always_comb begin
    state_d     = state_q;
    spr_d       = spr_q;
    col_d       = col_q;
    dcnt_d      = dcnt_q;
    row_d       = row_q;
    rom_addr_d  = rom_addr_q;
    row_valid_d = row_valid_q;
    overrun_d   = overrun_q;
    if (trig && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d     = CHECK;
          spr_d       = '0;
          row_valid_d = '0;
        end
      end
      CHECK: begin
        if (hit) begin
          row_d              = row_calc;
          row_valid_d[spr_q] = 1'b1;
          col_d              = 5'd0;
          rom_addr_d         = {img_cur, row_calc, 5'd0};
          state_d            = FETCH;
        end else if (spr_q == SPR_LAST) begin
          state_d = DONE;
        end else begin
          spr_d = spr_q + 1'b1;
        end
      end
      FETCH: begin
        if (col_q == 5'd31) begin
          dcnt_d  = '0;
          state_d = DRAIN;
        end else begin
          col_d      = col_q + 5'd1;
          rom_addr_d = {img_cur, row_q, col_q + 5'd1};
        end
      end
      DRAIN: begin
        if (dcnt_q == DRAIN_LAST) begin
          if (spr_q == SPR_LAST) begin
            state_d = DONE;
          end else begin
            spr_d   = spr_q + 1'b1;
            state_d = CHECK;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      spr_q       <= '0;
      col_q       <= '0;
      dcnt_q      <= '0;
      row_q       <= '0;
      rom_addr_q  <= '0;
      row_valid_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      spr_q       <= spr_d;
      col_q       <= col_d;
      dcnt_q      <= dcnt_d;
      row_q       <= row_d;
      rom_addr_q  <= rom_addr_d;
      row_valid_q <= row_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Snapshot of line number and sprite attributes at the trigger
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_row_q <= '0;
      en_snap_q  <= '0;
      for (int s = 0; s < NUM_SPR; s++) begin
        y_snap_q[s]   <= '0;
        img_snap_q[s] <= '0;
      end
    end else if (trig_idle) begin
      next_row_q <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
      en_snap_q  <= spr_en;
      for (int s = 0; s < NUM_SPR; s++) begin
        y_snap_q[s]   <= spr_y[s*10 +: 10];
        img_snap_q[s] <= spr_img[s*5 +: 5];
      end
    end
  end

  // Delay each issued column by the ROM latency so it lines up with rom_q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        pv_q[i] <= 1'b0;
        ps_q[i] <= '0;
        pc_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= (state_q == FETCH);
      ps_q[0] <= spr_q;
      pc_q[0] <= col_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        ps_q[i] <= ps_q[i-1];
        pc_q[i] <= pc_q[i-1];
      end
    end
  end

  assign rom_addr  = rom_addr_q;
  assign buf_we    = pv_q[ROM_LAT-1];
  assign buf_sel   = ps_q[ROM_LAT-1];
  assign buf_col   = pc_q[ROM_LAT-1];
  // Gated by the strobe so the data bus reads 0 under reset and between writes
  assign buf_data  = pv_q[ROM_LAT-1] ? rom_q : 4'd0;
  assign row_valid = row_valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Directed bench for sprite_row_fetcher: a vector table of line/attribute
// setups with hand-computed row_valid and busy length, plus a cycle model
// for the address stream and a scoreboard for the buffer writes.
module tb_sprite_row_fetcher;

  localparam int NS   = 4;
  localparam int LAT  = 1;
  localparam int MAXT = 170;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [3:0]  spr_en;
  logic [39:0] spr_y;
  logic [19:0] spr_img;
  logic [14:0] rom_addr;
  logic [3:0]  rom_q;
  logic        buf_we;
  logic [1:0]  buf_sel;
  logic [4:0]  buf_col;
  logic [3:0]  buf_data;
  logic [3:0]  row_valid;
  logic        busy;
  logic        overrun;

  int tests = 0;
  int fails = 0;

  sprite_row_fetcher #(.NUM_SPR(NS), .ROM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .spr_en(spr_en), .spr_y(spr_y), .spr_img(spr_img),
    .rom_addr(rom_addr), .rom_q(rom_q), .buf_we(buf_we), .buf_sel(buf_sel),
    .buf_col(buf_col), .buf_data(buf_data), .row_valid(row_valid),
    .busy(busy), .overrun(overrun)
  );

  // clock / reset
  always #10 clk = ~clk;

  // ROM model: pixel is a hash of the address, LAT cycles of latency
  function automatic logic [3:0] rom_f(input logic [14:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ {1'b0, a[14:12]} ^ 4'h5;
  endfunction

  logic [3:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_f(rom_addr);
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_q = rom_pipe[LAT-1];

  // vector table
  typedef struct packed {
    logic [9:0]  vc;
    logic [3:0]  en;
    logic [39:0] y;
    logic [19:0] img;
    logic [3:0]  rv;
    logic [7:0]  busy_n;
  } vec_t;

  vec_t vecs [8];

  // scoreboard: {t[7:0], sel[1:0], col[4:0], data[3:0]}
  logic [18:0] exp_q [$];
  logic        exp_f_a    [256];
  logic [14:0] exp_addr_a [256];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Cycle model of one sequence; t=1 is the cycle after the trigger edge
  task automatic build_model(input vec_t v);
    int t, nr, ys, row;
    logic [4:0]  img;
    logic [14:0] a;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      exp_f_a[i]    = 1'b0;
      exp_addr_a[i] = '0;
    end
    nr = (v.vc == 10'd524) ? 0 : int'(v.vc) + 1;
    t = 1;
    for (int s = 0; s < NS; s++) begin
      ys  = int'(v.y[s*10 +: 10]);
      img = v.img[s*5 +: 5];
      t++;
      if (v.en[s] && nr < 480 && nr >= ys && nr < ys + 32) begin
        row = nr - ys;
        for (int k = 0; k < 32; k++) begin
          a = 15'(int'(img) * 1024 + row * 32 + k);
          exp_f_a[t]    = 1'b1;
          exp_addr_a[t] = a;
          exp_q.push_back({8'(t + LAT), 2'(s), 5'(k), rom_f(a)});
          t++;
        end
        t += LAT;
      end
    end
  endtask

  // Apply one vector, trigger, and follow the sequence cycle by cycle.
  // chg_t: rewrite sprite 0 attributes; retrig_t: pulse hcount=HACTIVE;
  // abort_t: return right after sampling that cycle (for the reset test).
  task automatic run_vec(input int idx, input int chg_t, input int retrig_t,
                         input int abort_t);
    vec_t v;
    int   fell_t, addr_err, we_err, data_err, first_t;
    logic [18:0] e;
    v = vecs[idx];
    @(negedge clk);
    hcount  = 11'd1000;
    vcount  = v.vc;
    spr_en  = v.en;
    spr_y   = v.y;
    spr_img = v.img;
    build_model(v);
    @(negedge clk);
    hcount = 11'd1280;
    @(negedge clk);
    hcount = 11'd1281;
    fell_t = -1; addr_err = 0; we_err = 0; data_err = 0; first_t = -1;
    for (int t = 1; t <= MAXT; t++) begin
      if (!busy && fell_t < 0) fell_t = t;
      if (exp_f_a[t] && rom_addr !== exp_addr_a[t]) begin
        addr_err++;
        if (first_t < 0) first_t = t;
      end
      if (buf_we) begin
        if (exp_q.size() == 0) begin
          we_err++;
        end else begin
          e = exp_q.pop_front();
          if (e[18:11] != 8'(t) || {buf_sel, buf_col} !== e[10:4]) we_err++;
          else if (buf_data !== e[3:0]) data_err++;
        end
      end else if (exp_q.size() != 0 && exp_q[0][18:11] == 8'(t)) begin
        we_err++;
        void'(exp_q.pop_front());
      end
      if (t == abort_t) return;
      if (t == chg_t) begin
        spr_img[4:0] = 5'd9;
        spr_y[9:0]   = 10'd95;
      end
      if (t == retrig_t) hcount = 11'd1280;
      if (t == retrig_t + 1) hcount = 11'd1281;
      @(negedge clk);
    end
    we_err += exp_q.size();
    chk($sformatf("v%0d_addr_errs(first_t=%0d)", idx, first_t), addr_err, 0);
    chk($sformatf("v%0d_write_errs", idx), we_err, 0);
    chk($sformatf("v%0d_data_errs", idx), data_err, 0);
    chk($sformatf("v%0d_busy_cycles", idx), fell_t - 1, 32'(v.busy_n));
    chk($sformatf("v%0d_row_valid", idx), 32'(row_valid), 32'(v.rv));
  endtask

  int stray;

  initial begin
    // 0: basic single sprite, row 0
    vecs[0] = '{vc:10'd99,  en:4'b0001, y:{10'd0,10'd0,10'd0,10'd100},
                img:{5'd0,5'd0,5'd0,5'd3}, rv:4'b0001, busy_n:8'd38};
    // 1: last row 31
    vecs[1] = '{vc:10'd130, en:4'b0001, y:{10'd0,10'd0,10'd0,10'd100},
                img:{5'd0,5'd0,5'd0,5'd3}, rv:4'b0001, busy_n:8'd38};
    // 2: one past the bottom
    vecs[2] = '{vc:10'd131, en:4'b0001, y:{10'd0,10'd0,10'd0,10'd100},
                img:{5'd0,5'd0,5'd0,5'd3}, rv:4'b0000, busy_n:8'd5};
    // 3: one above the top
    vecs[3] = '{vc:10'd98,  en:4'b0001, y:{10'd0,10'd0,10'd0,10'd100},
                img:{5'd0,5'd0,5'd0,5'd3}, rv:4'b0000, busy_n:8'd5};
    // 4: all four hit, rows 20,10,0,30
    vecs[4] = '{vc:10'd119, en:4'b1111, y:{10'd90,10'd120,10'd110,10'd100},
                img:{5'd31,5'd7,5'd5,5'd3}, rv:4'b1111, busy_n:8'd137};
    // 5: frame wrap, next_row 0
    vecs[5] = '{vc:10'd524, en:4'b0001, y:{10'd0,10'd0,10'd0,10'd0},
                img:{5'd0,5'd0,5'd0,5'd2}, rv:4'b0001, busy_n:8'd38};
    // 6: next_row 480 is off-screen
    vecs[6] = '{vc:10'd479, en:4'b1111, y:{10'd470,10'd470,10'd470,10'd470},
                img:{5'd1,5'd1,5'd1,5'd1}, rv:4'b0000, busy_n:8'd5};
    // 7: sprites 1 and 3 enabled (rows 11, 21); disabled sprite 0 would hit
    vecs[7] = '{vc:10'd210, en:4'b1010, y:{10'd190,10'd0,10'd200,10'd211},
                img:{5'd12,5'd0,5'd20,5'd4}, rv:4'b1010, busy_n:8'd71};

    reset = 1'b1; hcount = '0; vcount = '0; spr_en = '0; spr_y = '0; spr_img = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({rom_addr, buf_we, buf_sel, buf_col, buf_data,
        row_valid, busy, overrun}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(i, -1, -1, -1);
    chk("overrun_clear_after_table", 32'(overrun), 32'd0);

    // attribute writes at column 10 must not disturb the running fetch
    run_vec(0, 12, -1, -1);
    // trigger during FETCH: ignored, but sticky overrun
    run_vec(0, -1, 20, -1);
    chk("overrun_set", 32'(overrun), 32'd1);
    repeat (5) @(negedge clk);
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // reset while sprite 0 is on column 15
    run_vec(0, -1, -1, 17);
    reset = 1'b1;
    #1;
    chk("midseq_reset_outputs", 32'({rom_addr, buf_we, buf_sel, buf_col, buf_data,
        row_valid, busy, overrun}), 32'd0);
    stray = 0;
    hcount = 11'd1000;
    repeat (3) begin
      @(negedge clk);
      if (buf_we) stray++;
    end
    reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (buf_we || busy) stray++;
    end
    chk("no_activity_after_reset", stray, 0);
    run_vec(0, -1, -1, -1);
    chk("overrun_after_reset_run", 32'(overrun), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
